// File: rtl/execute_feedback_ready_table.sv
// Per-physical-register ready bitmap: rename allocation clears entries, execute
// feedback sets them, and query ports read the bitmap with same-cycle feedback bypass.
module execute_feedback_ready_table #(
    parameter int PHY_REG_NUM      = 64,
    parameter int PHY_ID_WIDTH     = $clog2(PHY_REG_NUM),
    parameter int EXECUTE_UNIT_NUM = 8,
    parameter int RENAME_WIDTH     = 4,
    parameter int QUERY_NUM        = 8,
    parameter int CNT_WIDTH        = $clog2(PHY_REG_NUM + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [EXECUTE_UNIT_NUM-1:0]            fb_enable,
    input  logic [EXECUTE_UNIT_NUM*PHY_ID_WIDTH-1:0] fb_phy_id,
    input  logic [RENAME_WIDTH-1:0]                alloc_valid,
    input  logic [RENAME_WIDTH*PHY_ID_WIDTH-1:0]   alloc_phy_id,
    input  logic                                   flush,
    input  logic [QUERY_NUM*PHY_ID_WIDTH-1:0]      query_phy_id,
    output logic [QUERY_NUM-1:0]                   query_ready,
    output logic [PHY_REG_NUM-1:0]                 ready_vec,
    output logic [CNT_WIDTH-1:0]                   pending_count
);

    logic [PHY_REG_NUM-1:0] set_mask;
    logic [PHY_REG_NUM-1:0] clr_mask;
    logic [PHY_REG_NUM-1:0] next_ready;
    logic [CNT_WIDTH-1:0]   next_count;

    // Payloads are only decoded under their valid bit, so garbage ids on idle ports never reach state.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int c = 0; c < EXECUTE_UNIT_NUM; c++) begin
            if (fb_enable[c]) begin
                set_mask[fb_phy_id[c*PHY_ID_WIDTH +: PHY_ID_WIDTH]] = 1'b1;
            end
        end
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (alloc_valid[k]) begin
                clr_mask[alloc_phy_id[k*PHY_ID_WIDTH +: PHY_ID_WIDTH]] = 1'b1;
            end
        end
    end

    // Alloc outranks feedback on the same id: that feedback belongs to the stale producer.
    always_comb begin
        if (flush) begin
            next_ready = '1;
        end else begin
            next_ready = (ready_vec | set_mask) & ~clr_mask;
        end
        next_ready[0] = 1'b1;
    end

    // Count is rebuilt from the next bitmap so duplicate hits cannot skew it.
    always_comb begin
        next_count = '0;
        for (int p = 1; p < PHY_REG_NUM; p++) begin
            next_count = next_count + {{(CNT_WIDTH-1){1'b0}}, ~next_ready[p]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_vec     <= '1;
            pending_count <= '0;
        end else begin
            ready_vec     <= next_ready;
            pending_count <= next_count;
        end
    end

    always_comb begin
        query_ready = '0;
        for (int q = 0; q < QUERY_NUM; q++) begin
            query_ready[q] = ready_vec[query_phy_id[q*PHY_ID_WIDTH +: PHY_ID_WIDTH]]
                           | set_mask[query_phy_id[q*PHY_ID_WIDTH +: PHY_ID_WIDTH]]
                           | (query_phy_id[q*PHY_ID_WIDTH +: PHY_ID_WIDTH] == '0);
        end
    end

endmodule

// File: tb/tb_execute_feedback_ready_table.sv
// Bench for execute_feedback_ready_table: directed scenarios plus random traffic
// checked every cycle against a per-register behavioural model.
module tb_execute_feedback_ready_table;

    localparam int N  = 64;
    localparam int W  = 6;
    localparam int E  = 8;
    localparam int R  = 4;
    localparam int Q  = 8;
    localparam int CW = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [E-1:0]   fb_enable = '0;
    logic [E*W-1:0] fb_phy_id = '0;
    logic [R-1:0]   alloc_valid = '0;
    logic [R*W-1:0] alloc_phy_id = '0;
    logic           flush = 1'b0;
    logic [Q*W-1:0] query_phy_id = '0;
    logic [Q-1:0]   query_ready;
    logic [N-1:0]   ready_vec;
    logic [CW-1:0]  pending_count;

    execute_feedback_ready_table dut (
        .clk(clk), .rst(rst), .fb_enable(fb_enable), .fb_phy_id(fb_phy_id),
        .alloc_valid(alloc_valid), .alloc_phy_id(alloc_phy_id), .flush(flush),
        .query_phy_id(query_phy_id), .query_ready(query_ready),
        .ready_vec(ready_vec), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit m_ready[N];
    logic [N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_pending();
        int n = 0;
        for (int p = 1; p < N; p++) if (!m_ready[p]) n++;
        return n;
    endfunction

    function automatic logic [N-1:0] model_vec();
        logic [N-1:0] v;
        for (int p = 0; p < N; p++) v[p] = m_ready[p];
        return v;
    endfunction

    function automatic bit fb_hits(input int id);
        for (int c = 0; c < E; c++)
            if (fb_enable[c] && int'(fb_phy_id[c*W +: W]) == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit alloc_hits(input int id);
        for (int k = 0; k < R; k++)
            if (alloc_valid[k] && int'(alloc_phy_id[k*W +: W]) == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        fb_enable = '0;
        alloc_valid = '0;
        flush = 1'b0;
        fb_phy_id = {$urandom, $urandom};
        alloc_phy_id = $urandom;
        query_phy_id = {$urandom, $urandom};
    endtask

    task automatic set_fb(input int c, input int id);
        fb_enable[c] = 1'b1;
        fb_phy_id[c*W +: W] = W'(id);
    endtask

    task automatic set_alloc(input int k, input int id);
        alloc_valid[k] = 1'b1;
        alloc_phy_id[k*W +: W] = W'(id);
    endtask

    // One clock: check bypassed queries mid-cycle, advance the model, then check registered state.
    task automatic run_cycle();
        logic [Q-1:0] exp_query;
        logic [N-1:0] exp_vec;
        bit nxt[N];
        @(negedge clk);
        for (int q = 0; q < Q; q++) begin
            int id = int'(query_phy_id[q*W +: W]);
            exp_query[q] = (id == 0) || m_ready[id] || fb_hits(id);
        end
        check("query_ready", N'(query_ready), N'(exp_query));
        @(posedge clk);
        for (int p = 0; p < N; p++) begin
            if (p == 0 || !rst || flush) nxt[p] = 1'b1;
            else if (alloc_hits(p))      nxt[p] = 1'b0;
            else if (fb_hits(p))         nxt[p] = 1'b1;
            else                         nxt[p] = m_ready[p];
        end
        m_ready = nxt;
        exp_q.push_back(model_vec());
        #1;
        exp_vec = exp_q.pop_front();
        check("ready_vec", ready_vec, exp_vec);
        check("pending_count", N'(pending_count), N'(model_pending()));
    endtask

    initial begin
        for (int p = 0; p < N; p++) m_ready[p] = 1'b1;
        clear_inputs();
        rst = 1'b0;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        // Sweep every id through the query ports on an idle table.
        for (int b = 0; b < N / Q; b++) begin
            clear_inputs();
            for (int q = 0; q < Q; q++) query_phy_id[q*W +: W] = W'(b*Q + q);
            run_cycle();
            check("reset_query_all", N'(query_ready), N'({Q{1'b1}}));
        end
        check("reset_vec", ready_vec, {N{1'b1}});
        check("reset_count", N'(pending_count), 0);

        clear_inputs();
        set_alloc(0, 5); set_alloc(1, 9); set_alloc(2, 12); set_alloc(3, 40);
        run_cycle();
        check("alloc_bits", N'({ready_vec[40], ready_vec[12], ready_vec[9], ready_vec[5]}), 0);
        check("alloc_count", N'(pending_count), 4);

        clear_inputs();
        set_fb(3, 9);
        query_phy_id[0 +: W] = W'(9);
        #1;
        check("bypass_q9", N'(query_ready[0]), 1);
        run_cycle();
        check("fb_bit9", N'(ready_vec[9]), 1);
        check("fb_count", N'(pending_count), 3);

        clear_inputs();
        set_alloc(1, 20); set_fb(2, 20);
        run_cycle();
        check("conflict_bit20", N'(ready_vec[20]), 0);
        check("conflict_count", N'(pending_count), 4);
        clear_inputs();
        set_fb(0, 20); set_fb(5, 20);
        run_cycle();
        check("dup_fb_bit20", N'(ready_vec[20]), 1);
        check("dup_fb_count", N'(pending_count), 3);

        clear_inputs();
        set_alloc(0, 0); set_alloc(2, 0); set_fb(1, 0);
        query_phy_id[3*W +: W] = '0;
        #1;
        check("x0_query", N'(query_ready[3]), 1);
        run_cycle();
        check("x0_bit", N'(ready_vec[0]), 1);
        check("x0_count", N'(pending_count), 3);

        clear_inputs();
        set_alloc(0, 1); set_alloc(1, 2); set_alloc(2, 3); set_alloc(3, 4);
        run_cycle();
        clear_inputs();
        set_alloc(0, 41); set_alloc(1, 42); set_alloc(2, 43); set_alloc(3, 43);
        run_cycle();
        check("pre_flush_count", N'(pending_count), 10);
        clear_inputs();
        flush = 1'b1; set_alloc(0, 33); set_fb(0, 5);
        run_cycle();
        check("flush_vec", ready_vec, {N{1'b1}});
        check("flush_count", N'(pending_count), 0);

        clear_inputs();
        for (int k = 0; k < R; k++) set_alloc(k, 50 + k);
        run_cycle();
        clear_inputs();
        set_alloc(0, 60); set_alloc(1, 61);
        run_cycle();
        check("pre_rst_count", N'(pending_count), 6);
        clear_inputs();
        rst = 1'b0; set_alloc(0, 7);
        run_cycle();
        rst = 1'b1;
        check("midrst_vec", ready_vec, {N{1'b1}});
        check("midrst_count", N'(pending_count), 0);

        // Random traffic; ids drawn from a narrow window so collisions and duplicates are common.
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            for (int c = 0; c < E; c++)
                if ($urandom_range(0, 2) == 0) set_fb(c, $urandom_range(0, 23));
            for (int k = 0; k < R; k++)
                if ($urandom_range(0, 1) == 0) set_alloc(k, $urandom_range(0, 23));
            for (int q = 0; q < Q; q++)
                query_phy_id[q*W +: W] = W'($urandom_range(0, 3) == 0
                    ? int'(fb_phy_id[$urandom_range(0, E-1)*W +: W]) : $urandom_range(0, 31));
            flush = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 199) != 0);
            run_cycle();
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
